noc_link_rx_buffer: RTL and testbench

- Receive side of a router-to-router or router-to-endpoint link: consumes one credit-based router output port (send/data/dest/is_tail, credit return).
- Optionally pipelines the link in both directions, buffers flits in a FIFO sized to the upstream credit count, and presents them as a valid/ready stream.
- Returns one credit per flit consumed.
- Tracks packet framing and flags protocol violations.

---
 rtl/noc_link_pkg.sv | 24 ++
 rtl/noc_pipe_reg.sv | 23 ++
 rtl/noc_link_rx_buffer.sv | 186 ++++++++++++++++++
 tb/tb_noc_link_rx_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared types for the NoC link receive path: default flit layout, packet
// tracker states and the FIFO occupancy-width helper.
package noc_link_pkg;

  localparam int FLIT_W = 64;
  localparam int DEST_W = 6;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              is_tail;
  } flit_t;

  typedef enum logic {
    RX_IDLE,
    RX_BODY
  } rx_state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/noc_pipe_reg.sv
// Single link pipeline stage: the valid bit is reset, the payload is a plain
// register so it costs no reset routing.
module noc_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (rst) valid_out <= 1'b0;
    else     valid_out <= valid_in;
  end

  always_ff @(posedge clk) begin
    data_out <= data_in;
  end

endmodule

// File: rtl/noc_link_rx_buffer.sv
// Receive end of a credit-based NoC link: optional pipelining, credit-sized FIFO,
// credit return and packet-framing checks. Define NOC_LINK_RX_STATS_EN for counters.
module noc_link_rx_buffer
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH        = FLIT_W,
  parameter int DEST_WIDTH        = DEST_W,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int NUM_PIPELINE      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLIT_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic                  m_tail,
  output logic                  err_overflow,
  output logic                  err_dest_mismatch
`ifdef NOC_LINK_RX_STATS_EN
  ,
  output logic [31:0]           stat_flits,
  output logic [31:0]           stat_packets
`endif
);

  localparam int AW        = $clog2(FLIT_BUFFER_DEPTH);
  localparam int CW        = count_width(FLIT_BUFFER_DEPTH);
  localparam int FLIT_BITS = FLIT_WIDTH + DEST_WIDTH + 1;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } link_flit_t;

  logic [NUM_PIPELINE:0]                fwd_send;
  logic [NUM_PIPELINE:0][FLIT_BITS-1:0] fwd_flit;
  logic [NUM_PIPELINE:0]                crd_valid;
  logic [NUM_PIPELINE:0]                crd_unused;

  link_flit_t    push_flit;
  link_flit_t    head;
  link_flit_t    mem [FLIT_BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic          credit_q;

  rx_state_e             state;
  rx_state_e             state_next;
  logic [DEST_WIDTH-1:0] hdr_dest;
  logic                  latch_hdr;
  logic                  mismatch_hit;

  assign fwd_send[0] = send_in;
  assign fwd_flit[0] = {data_in, dest_in, is_tail_in};

  for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_fwd
    noc_pipe_reg #(.WIDTH(FLIT_BITS)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (fwd_send[i]),
      .data_in   (fwd_flit[i]),
      .valid_out (fwd_send[i+1]),
      .data_out  (fwd_flit[i+1])
    );
  end

  assign push      = fwd_send[NUM_PIPELINE];
  assign push_flit = fwd_flit[NUM_PIPELINE];

  assign full   = (count == CW'(FLIT_BUFFER_DEPTH));
  assign pop    = m_valid & m_ready;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still legal then.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_flit;
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_data  = head.data;
  assign m_dest  = head.dest;
  assign m_tail  = head.is_tail;

  always_ff @(posedge clk) begin
    if (rst) credit_q <= 1'b0;
    else     credit_q <= pop;
  end

  assign crd_valid[0]  = credit_q;
  assign crd_unused[0] = 1'b0;

  // Credit stages carry no payload; only the valid bit is meaningful.
  for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_crd
    noc_pipe_reg #(.WIDTH(1)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (crd_valid[i]),
      .data_in   (crd_unused[i]),
      .valid_out (crd_valid[i+1]),
      .data_out  (crd_unused[i+1])
    );
  end

  assign credit_out = crd_valid[NUM_PIPELINE];

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (latch_hdr) hdr_dest <= push_flit.dest;
  end

  // Framing is tracked on stored flits only; dropped flits never reach the tracker.
  always_comb begin
    state_next   = state;
    latch_hdr    = 1'b0;
    mismatch_hit = 1'b0;
    if (accept) begin
      case (state)
        RX_IDLE: begin
          if (!push_flit.is_tail) begin
            latch_hdr  = 1'b1;
            state_next = RX_BODY;
          end
        end
        RX_BODY: begin
          mismatch_hit = (push_flit.dest != hdr_dest);
          if (push_flit.is_tail) state_next = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow      <= 1'b0;
      err_dest_mismatch <= 1'b0;
    end else begin
      err_overflow      <= err_overflow | drop;
      err_dest_mismatch <= err_dest_mismatch | mismatch_hit;
    end
  end

`ifdef NOC_LINK_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits   <= '0;
      stat_packets <= '0;
    end else if (pop) begin
      stat_flits <= stat_flits + 32'd1;
      if (m_tail) stat_packets <= stat_packets + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_link_rx_buffer.sv
// Directed self-checking bench for noc_link_rx_buffer (DEPTH=4, two pipeline stages).
module tb_noc_link_rx_buffer;

  localparam int FW    = 64;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int NP    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] data_in;
  logic [DW-1:0] dest_in;
  logic          is_tail_in;
  logic          send_in;
  logic          credit_out;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_data;
  logic [DW-1:0] m_dest;
  logic          m_tail;
  logic          err_overflow;
  logic          err_dest_mismatch;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int            pop_cyc[$];
  logic [FW-1:0] pop_data[$];
  logic          pop_tail[$];
  int            crd_cyc[$];

  always #5 clk = ~clk;

  noc_link_rx_buffer #(
    .FLIT_WIDTH        (FW),
    .DEST_WIDTH        (DW),
    .FLIT_BUFFER_DEPTH (DEPTH),
    .NUM_PIPELINE      (NP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .dest_in           (dest_in),
    .is_tail_in        (is_tail_in),
    .send_in           (send_in),
    .credit_out        (credit_out),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_dest            (m_dest),
    .m_tail            (m_tail),
    .err_overflow      (err_overflow),
    .err_dest_mismatch (err_dest_mismatch)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pops and credit pulses are logged mid-cycle, tagged with the cycle index.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      pop_cyc.push_back(cyc);
      pop_data.push_back(m_data);
      pop_tail.push_back(m_tail);
    end
    if (credit_out) crd_cyc.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic send, input logic [FW-1:0] data,
                               input logic [DW-1:0] dest, input logic tail);
    send_in    = send;
    data_in    = data;
    dest_in    = dest;
    is_tail_in = tail;
  endtask

  task automatic clearLogs();
    pop_cyc.delete();
    pop_data.delete();
    pop_tail.delete();
    crd_cyc.delete();
  endtask

  task automatic doReset();
    rst     = 1'b1;
    m_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(2);
    rst = 1'b0;
    clearLogs();
  endtask

  function automatic logic [63:0] popDataAt(input int i);
    if (i < pop_data.size()) return pop_data[i];
    return '1;
  endfunction

  function automatic logic [63:0] popTailAt(input int i);
    if (i < pop_tail.size()) return 64'(pop_tail[i]);
    return '1;
  endfunction

  function automatic int popCycAt(input int i);
    if (i < pop_cyc.size()) return pop_cyc[i];
    return -1;
  endfunction

  function automatic int crdCycAt(input int i);
    if (i < crd_cyc.size()) return crd_cyc[i];
    return -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k0;

    // Reset state
    doReset();
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_credit", credit_out, 0);
    checkOutput("rst_err_ovf", err_overflow, 0);
    checkOutput("rst_err_dest", err_dest_mismatch, 0);

    // Single-flit packet: latency 1+NP to m_valid, credit 1+NP after the pop
    m_ready = 1'b1;
    applyStimulus(1'b1, 64'hA5, 6'h05, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= NP; i++) begin
      checkOutput("t1_early_valid", m_valid, 0);
      stepCycles(1);
    end
    checkOutput("t1_valid", m_valid, 1);
    checkOutput("t1_data", m_data, 64'hA5);
    checkOutput("t1_dest", m_dest, 6'h05);
    checkOutput("t1_tail", m_tail, 1);
    for (int i = 1; i <= NP; i++) begin
      stepCycles(1);
      checkOutput("t1_early_credit", credit_out, 0);
    end
    stepCycles(1);
    checkOutput("t1_credit", credit_out, 1);
    stepCycles(1);
    checkOutput("t1_credit_end", credit_out, 0);
    checkOutput("t1_err_ovf", err_overflow, 0);
    checkOutput("t1_err_dest", err_dest_mismatch, 0);

    // 4-flit packet into a stalled consumer, then drain back-to-back
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'h100 + 64'(i), 6'h11, (i == 3));
      stepCycles(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP + 2);
    checkOutput("t2_hold_valid", m_valid, 1);
    checkOutput("t2_hold_head", m_data, 64'h100);
    checkOutput("t2_no_credit_yet", crd_cyc.size(), 0);
    k0 = cyc;
    m_ready = 1'b1;
    stepCycles(4);
    m_ready = 1'b0;
    stepCycles(NP + 3);
    checkOutput("t2_pop_count", pop_data.size(), 4);
    checkOutput("t2_credit_count", crd_cyc.size(), 4);
    checkOutput("t2_first_pop_cyc", popCycAt(0), k0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_pop_data", popDataAt(i), 64'h100 + 64'(i));
      checkOutput("t2_pop_tail", popTailAt(i), (i == 3));
      checkOutput("t2_pop_cyc", popCycAt(i), k0 + i);
      checkOutput("t2_credit_cyc", crdCycAt(i), k0 + 1 + NP + i);
    end
    checkOutput("t2_empty", m_valid, 0);

    // Overflow: fifth flit into a full FIFO with no pop is dropped
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 64'h200 + 64'(i), 6'h22, 1'b1);
      stepCycles(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP - 1);
    checkOutput("t3_no_ovf_yet", err_overflow, 0);
    stepCycles(1);
    checkOutput("t3_ovf", err_overflow, 1);
    checkOutput("t3_head", m_data, 64'h200);
    m_ready = 1'b1;
    stepCycles(6);
    m_ready = 1'b0;
    stepCycles(NP + 3);
    checkOutput("t3_pop_count", pop_data.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("t3_pop_data", popDataAt(i), 64'h200 + 64'(i));
    checkOutput("t3_credit_count", crd_cyc.size(), 4);
    checkOutput("t3_ovf_sticky", err_overflow, 1);
    checkOutput("t3_err_dest", err_dest_mismatch, 0);

    // Full FIFO: push coinciding with a pop is accepted
    doReset();
    checkOutput("t4_rst_ovf", err_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'h300 + 64'(i), 6'h33, 1'b1);
      stepCycles(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP + 2);
    applyStimulus(1'b1, 64'h304, 6'h33, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP - 1);
    m_ready = 1'b1;
    stepCycles(1);
    m_ready = 1'b0;
    checkOutput("t4_no_ovf", err_overflow, 0);
    checkOutput("t4_valid", m_valid, 1);
    checkOutput("t4_head", m_data, 64'h301);
    m_ready = 1'b1;
    stepCycles(6);
    m_ready = 1'b0;
    stepCycles(NP + 3);
    checkOutput("t4_pop_count", pop_data.size(), 5);
    for (int i = 0; i < 5; i++)
      checkOutput("t4_pop_data", popDataAt(i), 64'h300 + 64'(i));
    checkOutput("t4_credit_count", crd_cyc.size(), 5);

    // Destination mismatch inside a packet, flag survives a clean packet
    doReset();
    m_ready = 1'b1;
    applyStimulus(1'b1, 64'h500, 6'h05, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 64'h501, 6'h05, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 64'h502, 6'h09, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP - 1);
    checkOutput("t5_no_mismatch_yet", err_dest_mismatch, 0);
    stepCycles(1);
    checkOutput("t5_mismatch", err_dest_mismatch, 1);
    stepCycles(2);
    applyStimulus(1'b1, 64'h510, 6'h07, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 64'h511, 6'h07, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP + 4);
    checkOutput("t5_mismatch_sticky", err_dest_mismatch, 1);
    checkOutput("t5_pop_count", pop_data.size(), 5);
    checkOutput("t5_pop0", popDataAt(0), 64'h500);
    checkOutput("t5_pop2", popDataAt(2), 64'h502);
    checkOutput("t5_pop2_tail", popTailAt(2), 1);
    checkOutput("t5_pop4", popDataAt(4), 64'h511);
    checkOutput("t5_err_ovf", err_overflow, 0);

    // Reset mid-packet with a credit in flight, then a fresh single-flit packet
    doReset();
    applyStimulus(1'b1, 64'h600, 6'h0A, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 64'h601, 6'h0C, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP + 2);
    checkOutput("t6_buffered", m_valid, 1);
    checkOutput("t6_mismatch_set", err_dest_mismatch, 1);
    clearLogs();
    m_ready = 1'b1;
    stepCycles(1);
    m_ready = 1'b0;
    checkOutput("t6_one_pop", pop_data.size(), 1);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("t6_rst_valid", m_valid, 0);
    checkOutput("t6_rst_credit", credit_out, 0);
    checkOutput("t6_rst_err_dest", err_dest_mismatch, 0);
    checkOutput("t6_rst_err_ovf", err_overflow, 0);
    rst = 1'b0;
    stepCycles(NP + 4);
    checkOutput("t6_credit_flushed", crd_cyc.size(), 0);
    checkOutput("t6_still_empty", m_valid, 0);
    applyStimulus(1'b1, 64'h6B0, 6'h0B, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycles(NP);
    checkOutput("t6_new_valid", m_valid, 1);
    checkOutput("t6_new_data", m_data, 64'h6B0);
    checkOutput("t6_new_dest", m_dest, 6'h0B);
    checkOutput("t6_new_tail", m_tail, 1);
    checkOutput("t6_new_no_mismatch", err_dest_mismatch, 0);
    m_ready = 1'b1;
    stepCycles(1);
    m_ready = 1'b0;
    stepCycles(NP + 2);
    checkOutput("t6_new_credit", crd_cyc.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
